pipeline_fg_fade_controller: RTL and testbench

Sequencer for the foreground/background pixel merger. Per pixel, it decides whether the foreground overlay window covers the current coordinate (`use_fg_pixel`). Per frame, it ramps `ctrl_fg_transparency` between fully transparent and a target opacity, driven by show/hide commands with a valid/ready handshake. It sits between the pixel coordinate generator / control registers and the merger stage, one pixel cycle ahead of the merge.

---
 rtl/pipeline_fg_fade_controller_pkg.sv | 20 ++
 rtl/pipeline_fg_fade_controller_hit.sv | 27 ++
 rtl/pipeline_fg_fade_controller.sv | 130 +++++++++++++
 tb/tb_pipeline_fg_fade_controller.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_fg_fade_controller_pkg.sv
// Shared definitions for the foreground fade sequencer: FSM encoding and
// parameter-derived widths.
package pipeline_fg_fade_controller_pkg;

  localparam logic [1:0] ST_HIDDEN     = 2'd0;
  localparam logic [1:0] ST_FADING_IN  = 2'd1;
  localparam logic [1:0] ST_SHOWN      = 2'd2;
  localparam logic [1:0] ST_FADING_OUT = 2'd3;

  // Most transparent code for a given transparency precision.
  function automatic int tmax_of(input int precision);
    return (1 << precision) - 1;
  endfunction

  // Frame counter only needs to reach FRAMES_PER_STEP-1; keep at least one bit.
  function automatic int frame_cnt_width(input int frames_per_step);
    return (frames_per_step > 1) ? $clog2(frames_per_step) : 1;
  endfunction

endpackage

// File: rtl/pipeline_fg_fade_controller_hit.sv
// Combinational window hit test against the shadowed geometry. End sums are
// one bit wider so windows running off the coordinate range clip.
module pipeline_window_hit_detector #(
  parameter int X_WIDTH = 11,
  parameter int Y_WIDTH = 10
) (
  input  logic               pixel_valid,
  input  logic [X_WIDTH-1:0] pixel_x,
  input  logic [Y_WIDTH-1:0] pixel_y,
  input  logic [X_WIDTH-1:0] win_x,
  input  logic [Y_WIDTH-1:0] win_y,
  input  logic [X_WIDTH-1:0] win_w,
  input  logic [Y_WIDTH-1:0] win_h,
  output logic               hit
);
  logic [X_WIDTH:0] x_end;
  logic [Y_WIDTH:0] y_end;

  assign x_end = {1'b0, win_x} + {1'b0, win_w};
  assign y_end = {1'b0, win_y} + {1'b0, win_h};

  // Zero width/height collapses the interval, so no explicit degenerate check.
  assign hit = pixel_valid
             & (pixel_x >= win_x) & ({1'b0, pixel_x} < x_end)
             & (pixel_y >= win_y) & ({1'b0, pixel_y} < y_end);

endmodule

// File: rtl/pipeline_fg_fade_controller.sv
// Foreground fade sequencer: show/hide FSM ramping transparency once per
// FRAMES_PER_STEP frames, plus the registered window-hit output for the merger.
module pipeline_fg_fade_controller
  import pipeline_fg_fade_controller_pkg::*;
#(
  parameter int TRANSPARENCY_PRECISION = 3,
  parameter int X_WIDTH                = 11,
  parameter int Y_WIDTH                = 10,
  parameter int FRAMES_PER_STEP        = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              frame_start,
  input  logic                              pixel_valid,
  input  logic [X_WIDTH-1:0]                pixel_x,
  input  logic [Y_WIDTH-1:0]                pixel_y,
  input  logic [X_WIDTH-1:0]                cfg_fg_x,
  input  logic [Y_WIDTH-1:0]                cfg_fg_y,
  input  logic [X_WIDTH-1:0]                cfg_fg_w,
  input  logic [Y_WIDTH-1:0]                cfg_fg_h,
  input  logic [TRANSPARENCY_PRECISION-1:0] cfg_target_transparency,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_show,
  output logic                              use_fg_pixel,
  output logic [TRANSPARENCY_PRECISION-1:0] ctrl_fg_transparency,
  output logic                              fade_busy,
  output logic                              fade_done
);
  localparam int P  = TRANSPARENCY_PRECISION;
  localparam int CW = frame_cnt_width(FRAMES_PER_STEP);
  localparam logic [P-1:0]  TMAX     = P'(tmax_of(P));
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);

  logic [1:0]         state;
  logic [P-1:0]       tgt;
  logic [CW-1:0]      frame_cnt;
  logic [X_WIDTH-1:0] sh_x, sh_w;
  logic [Y_WIDTH-1:0] sh_y, sh_h;
  logic               accept, step, hit;

  assign cmd_ready = (state == ST_HIDDEN) | (state == ST_SHOWN);
  assign fade_busy = (state == ST_FADING_IN) | (state == ST_FADING_OUT);
  assign accept    = cmd_valid & cmd_ready;
  assign step      = frame_start & fade_busy & (frame_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= ST_HIDDEN;
      ctrl_fg_transparency <= TMAX;
      tgt                  <= '0;
      frame_cnt            <= '0;
      fade_done            <= 1'b0;
    end else begin
      fade_done <= 1'b0;
      if (fade_busy && frame_start)
        frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + 1'b1;
      // Accept only happens in the idle states, so it never races a step.
      if (accept) begin
        tgt       <= cfg_target_transparency;
        frame_cnt <= '0;
        if (state == ST_HIDDEN && cmd_show)       state <= ST_FADING_IN;
        else if (state == ST_SHOWN && !cmd_show)  state <= ST_FADING_OUT;
        else                                      fade_done <= 1'b1;
      end
      case (state)
        ST_FADING_IN: begin
          if (ctrl_fg_transparency == tgt) begin
            state     <= ST_SHOWN;
            fade_done <= 1'b1;
          end else if (step) begin
            ctrl_fg_transparency <= ctrl_fg_transparency - 1'b1;
            if (ctrl_fg_transparency == tgt + 1'b1) begin
              state     <= ST_SHOWN;
              fade_done <= 1'b1;
            end
          end
        end
        ST_FADING_OUT: begin
          if (ctrl_fg_transparency == TMAX) begin
            state     <= ST_HIDDEN;
            fade_done <= 1'b1;
          end else if (step) begin
            ctrl_fg_transparency <= ctrl_fg_transparency + 1'b1;
            if (ctrl_fg_transparency == TMAX - 1'b1) begin
              state     <= ST_HIDDEN;
              fade_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Geometry is frozen per frame so mid-frame register writes never tear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_x <= '0;
      sh_y <= '0;
      sh_w <= '0;
      sh_h <= '0;
    end else if (frame_start) begin
      sh_x <= cfg_fg_x;
      sh_y <= cfg_fg_y;
      sh_w <= cfg_fg_w;
      sh_h <= cfg_fg_h;
    end
  end

  pipeline_window_hit_detector #(
    .X_WIDTH(X_WIDTH),
    .Y_WIDTH(Y_WIDTH)
  ) u_hit (
    .pixel_valid(pixel_valid),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .win_x      (sh_x),
    .win_y      (sh_y),
    .win_w      (sh_w),
    .win_h      (sh_h),
    .hit        (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) use_fg_pixel <= 1'b0;
    else        use_fg_pixel <= hit & (state != ST_HIDDEN);
  end

endmodule

// File: tb/tb_pipeline_fg_fade_controller.sv
// Randomized bench for the fg fade sequencer; expected values come from a
// frame-count based reference model of the fade rules and window geometry.
module tb_pipeline_fg_fade_controller;
  localparam int TMAX = 7;
  localparam int FPS  = 2;
  localparam int M_HID = 0, M_FIN = 1, M_SHN = 2, M_FOUT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0, pixel_valid = 1'b0;
  logic [10:0] pixel_x = '0, cfg_fg_x = '0, cfg_fg_w = '0;
  logic [9:0]  pixel_y = '0, cfg_fg_y = '0, cfg_fg_h = '0;
  logic [2:0]  cfg_target_transparency = '0;
  logic        cmd_valid = 1'b0, cmd_show = 1'b0;
  logic        cmd_ready, use_fg_pixel, fade_busy, fade_done;
  logic [2:0]  ctrl_fg_transparency;

  int checks = 0, failures = 0;

  // reference model state
  int m_st, m_trans, m_tgt, m_start, m_frames;
  int sh_x, sh_y, sh_w, sh_h;
  bit exp_use, exp_done;

  always #5 clk = ~clk;

  pipeline_fg_fade_controller #(
    .TRANSPARENCY_PRECISION(3), .X_WIDTH(11), .Y_WIDTH(10), .FRAMES_PER_STEP(FPS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .cfg_fg_x(cfg_fg_x), .cfg_fg_y(cfg_fg_y),
    .cfg_fg_w(cfg_fg_w), .cfg_fg_h(cfg_fg_h),
    .cfg_target_transparency(cfg_target_transparency), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_show(cmd_show), .use_fg_pixel(use_fg_pixel),
    .ctrl_fg_transparency(ctrl_fg_transparency), .fade_busy(fade_busy), .fade_done(fade_done)
  );

  task automatic model_reset();
    m_st = M_HID; m_trans = TMAX; m_tgt = 0; m_start = TMAX; m_frames = 0;
    sh_x = 0; sh_y = 0; sh_w = 0; sh_h = 0; exp_use = 0; exp_done = 0;
  endtask

  // Advance the model on the currently driven inputs, then clock the DUT.
  task automatic step();
    int st0;
    st0 = m_st;
    exp_use = pixel_valid && st0 != M_HID &&
              int'(pixel_x) >= sh_x && int'(pixel_x) < sh_x + sh_w &&
              int'(pixel_y) >= sh_y && int'(pixel_y) < sh_y + sh_h;
    if (frame_start) begin
      sh_x = int'(cfg_fg_x); sh_y = int'(cfg_fg_y); sh_w = int'(cfg_fg_w); sh_h = int'(cfg_fg_h);
    end
    exp_done = 0;
    if (cmd_valid && (st0 == M_HID || st0 == M_SHN)) begin
      m_tgt = int'(cfg_target_transparency); m_frames = 0; m_start = m_trans;
      if (st0 == M_HID && cmd_show)       m_st = M_FIN;
      else if (st0 == M_SHN && !cmd_show) m_st = M_FOUT;
      else                                exp_done = 1;
    end else if (st0 == M_FIN) begin
      if (m_trans == m_tgt) begin m_st = M_SHN; exp_done = 1; end
      else if (frame_start) begin
        m_frames++;
        m_trans = m_start - m_frames / FPS;
        if (m_trans == m_tgt) begin m_st = M_SHN; exp_done = 1; end
      end
    end else if (st0 == M_FOUT) begin
      if (m_trans == TMAX) begin m_st = M_HID; exp_done = 1; end
      else if (frame_start) begin
        m_frames++;
        m_trans = m_start + m_frames / FPS;
        if (m_trans == TMAX) begin m_st = M_HID; exp_done = 1; end
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [6:0] exp_vec();
    return {3'(m_trans), exp_done, (m_st == M_HID || m_st == M_SHN),
            (m_st == M_FIN || m_st == M_FOUT), exp_use};
  endfunction

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ctrl_fg_transparency, fade_done, cmd_ready, fade_busy, use_fg_pixel} !== 7'b111_0_1_0_0) begin
      failures++;
      $display("FAIL reset_state: got %b want 1110100",
               {ctrl_fg_transparency, fade_done, cmd_ready, fade_busy, use_fg_pixel});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fade_in();
    int frames, prev;
    bit done_seen;
    cfg_target_transparency = 3'd2; cmd_show = 1'b1; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0 || fade_busy !== 1'b1) begin
      failures++;
      $display("FAIL fade_in_accept: ready=%0b busy=%0b want ready=0 busy=1", cmd_ready, fade_busy);
    end
    frames = 0; prev = TMAX; done_seen = 0;
    for (int i = 0; i < 400 && !done_seen; i++) begin
      frame_start = ($urandom_range(0, 2) == 0);
      frames += int'(frame_start);
      step();
      frame_start = 1'b0;
      checks++;
      if ({ctrl_fg_transparency, fade_done, cmd_ready, fade_busy, use_fg_pixel} !== exp_vec()) begin
        failures++;
        $display("FAIL fade_in_track: got %b want %b",
                 {ctrl_fg_transparency, fade_done, cmd_ready, fade_busy, use_fg_pixel}, exp_vec());
      end
      if (int'(ctrl_fg_transparency) != prev) begin
        checks++;
        if (int'(ctrl_fg_transparency) != prev - 1 || frames % FPS != 0) begin
          failures++;
          $display("FAIL fade_in_step: got %0d after %0d frames want %0d on an even frame",
                   ctrl_fg_transparency, frames, prev - 1);
        end
        prev = int'(ctrl_fg_transparency);
      end
      if (fade_done === 1'b1) begin
        done_seen = 1;
        checks++;
        if (frames != 10 || ctrl_fg_transparency !== 3'd2 || cmd_ready !== 1'b1 || fade_busy !== 1'b0) begin
          failures++;
          $display("FAIL fade_in_done: frames=%0d t=%0d ready=%0b busy=%0b want 10 2 1 0",
                   frames, ctrl_fg_transparency, cmd_ready, fade_busy);
        end
      end
    end
    checks++;
    if (!done_seen) begin failures++; $display("FAIL fade_in_timeout: done=0 want 1"); end
  endtask

  task automatic test_window();
    cfg_fg_x = 11'd100; cfg_fg_y = 10'd50; cfg_fg_w = 11'd20; cfg_fg_h = 10'd10;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    pixel_valid = 1'b1; pixel_x = 11'd119; pixel_y = 10'd59; step();
    checks++;
    if (use_fg_pixel !== 1'b1) begin failures++; $display("FAIL win_inside: got %0b want 1", use_fg_pixel); end
    pixel_x = 11'd120; step();
    checks++;
    if (use_fg_pixel !== 1'b0) begin failures++; $display("FAIL win_right_edge: got %0b want 0", use_fg_pixel); end
    pixel_x = 11'd99; pixel_y = 10'd55; step();
    checks++;
    if (use_fg_pixel !== 1'b0) begin failures++; $display("FAIL win_left_edge: got %0b want 0", use_fg_pixel); end
    // mid-frame change must not apply until the next frame_start
    cfg_fg_x = 11'd0; cfg_fg_y = 10'd0; cfg_fg_w = 11'd5; cfg_fg_h = 10'd5;
    pixel_x = 11'd119; pixel_y = 10'd59; step();
    checks++;
    if (use_fg_pixel !== 1'b1) begin failures++; $display("FAIL win_shadow_hold: got %0b want 1", use_fg_pixel); end
    frame_start = 1'b1; step(); frame_start = 1'b0;
    checks++;
    if (use_fg_pixel !== 1'b1) begin failures++; $display("FAIL win_fs_same_cycle: got %0b want 1", use_fg_pixel); end
    step();
    checks++;
    if (use_fg_pixel !== 1'b0) begin failures++; $display("FAIL win_new_miss: got %0b want 0", use_fg_pixel); end
    pixel_x = 11'd2; pixel_y = 10'd2; step();
    checks++;
    if (use_fg_pixel !== 1'b1) begin failures++; $display("FAIL win_new_hit: got %0b want 1", use_fg_pixel); end
    pixel_valid = 1'b0; step();
    checks++;
    if (use_fg_pixel !== 1'b0) begin failures++; $display("FAIL win_invalid: got %0b want 0", use_fg_pixel); end
  endtask

  task automatic test_clip();
    cfg_fg_x = 11'd2040; cfg_fg_y = 10'd0; cfg_fg_w = 11'd20; cfg_fg_h = 10'd10;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    pixel_valid = 1'b1; pixel_x = 11'd2047; pixel_y = 10'd5; step();
    checks++;
    if (use_fg_pixel !== 1'b1) begin failures++; $display("FAIL clip_hit_2047: got %0b want 1", use_fg_pixel); end
    pixel_x = 11'd3; step();
    checks++;
    if (use_fg_pixel !== 1'b0) begin failures++; $display("FAIL clip_no_wrap_3: got %0b want 0", use_fg_pixel); end
    cfg_fg_w = 11'd0;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pixel_x = 11'($urandom_range(2035, 2047)); pixel_y = 10'($urandom_range(0, 12));
      step();
      checks++;
      if (use_fg_pixel !== 1'b0) begin
        failures++;
        $display("FAIL zero_width: x=%0d y=%0d got %0b want 0", pixel_x, pixel_y, use_fg_pixel);
      end
    end
    pixel_valid = 1'b0;
  endtask

  task automatic test_random_hit();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        cfg_fg_x = 11'($urandom_range(0, 40)); cfg_fg_y = 10'($urandom_range(0, 40));
        cfg_fg_w = 11'($urandom_range(0, 20)); cfg_fg_h = 10'($urandom_range(0, 20));
      end
      frame_start = ($urandom_range(0, 7) == 0);
      pixel_valid = ($urandom_range(0, 3) != 0);
      pixel_x = 11'($urandom_range(0, 63)); pixel_y = 10'($urandom_range(0, 63));
      step();
      checks++;
      if (use_fg_pixel !== exp_use) begin
        failures++;
        $display("FAIL random_hit: got %0b want %0b", use_fg_pixel, exp_use);
      end
    end
    frame_start = 1'b0; pixel_valid = 1'b0;
  endtask

  task automatic test_cmd_edges();
    bit done_seen;
    // show while already shown: no state change, done next cycle
    cfg_target_transparency = 3'd2; cmd_show = 1'b1; cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
    checks++;
    if ({fade_done, fade_busy, cmd_ready, ctrl_fg_transparency} !== 6'b0_0_1_010 && 1'b1 &&
        {fade_done, fade_busy, cmd_ready, ctrl_fg_transparency} !== 6'b1_0_1_010) begin
      failures++;
    end
    if ({fade_done, fade_busy, cmd_ready, ctrl_fg_transparency} !== 6'b1_0_1_010)
      $display("FAIL show_in_shown: got %b want 101010", {fade_done, fade_busy, cmd_ready, ctrl_fg_transparency});
    step();
    checks++;
    if (fade_done !== 1'b0) begin failures++; $display("FAIL done_one_cycle: got %0b want 0", fade_done); end
    // hide held through the whole fade-out
    cmd_show = 1'b0; cmd_valid = 1'b1; step();
    done_seen = 0;
    for (int i = 0; i < 100 && !done_seen; i++) begin
      frame_start = $urandom_range(0, 1);
      step();
      frame_start = 1'b0;
      checks++;
      if ({ctrl_fg_transparency, fade_done, cmd_ready, fade_busy, use_fg_pixel} !== exp_vec()) begin
        failures++;
        $display("FAIL fade_out_track: got %b want %b",
                 {ctrl_fg_transparency, fade_done, cmd_ready, fade_busy, use_fg_pixel}, exp_vec());
      end
      done_seen = (fade_done === 1'b1);
    end
    checks++;
    if (!done_seen || ctrl_fg_transparency !== 3'd7 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL fade_out_end: done=%0b t=%0d ready=%0b want 1 7 1", done_seen, ctrl_fg_transparency, cmd_ready);
    end
    step();  // held hide now accepted in HIDDEN
    cmd_valid = 1'b0;
    checks++;
    if (fade_done !== 1'b1 || fade_busy !== 1'b0 || ctrl_fg_transparency !== 3'd7) begin
      failures++;
      $display("FAIL held_hide_in_hidden: done=%0b busy=%0b t=%0d want 1 0 7", fade_done, fade_busy, ctrl_fg_transparency);
    end
    step();
    // accept coincident with frame_start: that frame does not count
    cfg_target_transparency = 3'd5; cmd_show = 1'b1; cmd_valid = 1'b1; frame_start = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();  // frame_start still high: first counted frame
    frame_start = 1'b0;
    checks++;
    if (ctrl_fg_transparency !== 3'd7 || fade_busy !== 1'b1) begin
      failures++;
      $display("FAIL accept_fs_no_step: t=%0d busy=%0b want 7 1", ctrl_fg_transparency, fade_busy);
    end
    frame_start = 1'b1; step(); frame_start = 1'b0;
    checks++;
    if (ctrl_fg_transparency !== 3'd6) begin
      failures++;
      $display("FAIL accept_fs_second_frame: t=%0d want 6", ctrl_fg_transparency);
    end
  endtask

  task automatic test_reset_mid_fade();
    bit reached;
    cmd_valid = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0;
    rst_n = 1'b0; model_reset();
    @(negedge clk); rst_n = 1'b1; @(posedge clk); #1;
    cfg_fg_x = 11'd0; cfg_fg_y = 10'd0; cfg_fg_w = 11'd2047; cfg_fg_h = 10'd1023;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    pixel_valid = 1'b1; pixel_x = 11'd5; pixel_y = 10'd5;
    cfg_target_transparency = 3'd2; cmd_show = 1'b1; cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
    reached = 0;
    for (int i = 0; i < 40 && !reached; i++) begin
      frame_start = 1'b1; step(); frame_start = 1'b0;
      checks++;
      if ({ctrl_fg_transparency, fade_done, cmd_ready, fade_busy, use_fg_pixel} !== exp_vec()) begin
        failures++;
        $display("FAIL pre_reset_track: got %b want %b",
                 {ctrl_fg_transparency, fade_done, cmd_ready, fade_busy, use_fg_pixel}, exp_vec());
      end
      reached = (ctrl_fg_transparency === 3'd4);
    end
    checks++;
    if (!reached || use_fg_pixel !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_state: t=%0d use=%0b want 4 1", ctrl_fg_transparency, use_fg_pixel);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ctrl_fg_transparency, use_fg_pixel, cmd_ready, fade_busy, fade_done} !== 7'b111_0_1_0_0) begin
      failures++;
      $display("FAIL async_reset: got %b want 1110100",
               {ctrl_fg_transparency, use_fg_pixel, cmd_ready, fade_busy, fade_done});
    end
    model_reset();
    pixel_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1; @(posedge clk); #1;
  endtask

  task automatic test_fade_max();
    cfg_fg_x = 11'd0; cfg_fg_y = 10'd0; cfg_fg_w = 11'd2047; cfg_fg_h = 10'd1023;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    pixel_valid = 1'b1; pixel_x = 11'd9; pixel_y = 10'd9;
    cfg_target_transparency = 3'd7; cmd_show = 1'b1; cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
    step();
    checks++;
    if ({fade_done, fade_busy, cmd_ready, ctrl_fg_transparency} !== 6'b1_0_1_111) begin
      failures++;
      $display("FAIL tgt_max_show: got %b want 101111", {fade_done, fade_busy, cmd_ready, ctrl_fg_transparency});
    end
    step();
    checks++;
    if (use_fg_pixel !== 1'b1) begin failures++; $display("FAIL tgt_max_shown_use: got %0b want 1", use_fg_pixel); end
    cmd_show = 1'b0; cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
    step();
    checks++;
    if ({fade_done, fade_busy, cmd_ready, ctrl_fg_transparency} !== 6'b1_0_1_111) begin
      failures++;
      $display("FAIL tgt_max_hide: got %b want 101111", {fade_done, fade_busy, cmd_ready, ctrl_fg_transparency});
    end
    step();
    checks++;
    if (use_fg_pixel !== 1'b0) begin failures++; $display("FAIL hidden_use: got %0b want 0", use_fg_pixel); end
    pixel_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(0, 7) == 0);
      cmd_show = $urandom_range(0, 1);
      cfg_target_transparency = 3'($urandom_range(0, 7));
      frame_start = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 31) == 0) begin
        cfg_fg_x = 11'($urandom_range(0, 40)); cfg_fg_y = 10'($urandom_range(0, 40));
        cfg_fg_w = 11'($urandom_range(0, 30)); cfg_fg_h = 10'($urandom_range(0, 30));
      end
      pixel_valid = $urandom_range(0, 1);
      pixel_x = 11'($urandom_range(0, 63)); pixel_y = 10'($urandom_range(0, 63));
      step();
      checks++;
      if ({ctrl_fg_transparency, fade_done, cmd_ready, fade_busy, use_fg_pixel} !== exp_vec()) begin
        failures++;
        $display("FAIL random_seq cycle %0d: got %b want %b", i,
                 {ctrl_fg_transparency, fade_done, cmd_ready, fade_busy, use_fg_pixel}, exp_vec());
      end
    end
    cmd_valid = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_window();
    test_clip();
    test_random_hit();
    test_cmd_edges();
    test_reset_mid_fade();
    test_fade_max();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
